// File: rtl/dual_req_scheduler.sv
// Round-robin scheduler sharing one multi-cycle unit between two requesters,
// with timeout abort and saturating per-requester completion counters.
module dual_req_scheduler #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req1,
    input  logic [1:0] cmd1,
    input  logic       req2,
    input  logic [1:0] cmd2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       done1,
    output logic       done2,
    output logic       err,
    output logic       unit_start,
    output logic [1:0] unit_cmd,
    output logic       unit_src,
    input  logic       unit_done,
    input  logic       clr,
    output logic [2:0] cnt1,
    output logic [2:0] cnt2
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e     r_state;
    logic       r_last_src;
    logic [7:0] r_timer;
    logic       r_gnt1;
    logic       r_gnt2;
    logic       r_done1;
    logic       r_done2;
    logic       r_err;
    logic       r_start;
    logic [1:0] r_unit_cmd;
    logic       r_unit_src;
    logic [2:0] r_cnt1;
    logic [2:0] r_cnt2;

    logic       w_any_req;
    logic       w_sel_src;
    logic [1:0] w_sel_cmd;
    logic       w_complete;

    // On a tie the requester that was not served last wins.
    assign w_any_req  = req1 | req2;
    assign w_sel_src  = (req1 & req2) ? ~r_last_src : req2;
    assign w_sel_cmd  = w_sel_src ? cmd2 : cmd1;
    assign w_complete = (r_state == StWait) & unit_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_last_src <= 1'b1;
            r_timer    <= 8'd0;
            r_gnt1     <= 1'b0;
            r_gnt2     <= 1'b0;
            r_done1    <= 1'b0;
            r_done2    <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_unit_cmd <= 2'b00;
            r_unit_src <= 1'b0;
        end else begin
            r_gnt1  <= 1'b0;
            r_gnt2  <= 1'b0;
            r_done1 <= 1'b0;
            r_done2 <= 1'b0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_unit_cmd <= w_sel_cmd;
                        r_unit_src <= w_sel_src;
                        r_gnt1     <= ~w_sel_src;
                        r_gnt2     <= w_sel_src;
                        r_start    <= 1'b1;
                        r_state    <= StIssue;
                    end
                end
                StIssue: begin
                    r_timer <= 8'd0;
                    r_state <= StWait;
                end
                StWait: begin
                    // Completion beats a timeout landing on the same cycle.
                    if (unit_done) begin
                        r_done1    <= ~r_unit_src;
                        r_done2    <= r_unit_src;
                        r_last_src <= r_unit_src;
                        r_state    <= StIdle;
                    end else if (r_timer == TimerLast) begin
                        r_err      <= 1'b1;
                        r_last_src <= r_unit_src;
                        r_state    <= StIdle;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt1 <= 3'd0;
            r_cnt2 <= 3'd0;
        end else if (clr) begin
            r_cnt1 <= 3'd0;
            r_cnt2 <= 3'd0;
        end else if (w_complete) begin
            if (!r_unit_src && r_cnt1 != 3'd7) r_cnt1 <= r_cnt1 + 3'd1;
            if (r_unit_src && r_cnt2 != 3'd7)  r_cnt2 <= r_cnt2 + 3'd1;
        end
    end

    assign gnt1       = r_gnt1;
    assign gnt2       = r_gnt2;
    assign done1      = r_done1;
    assign done2      = r_done2;
    assign err        = r_err;
    assign unit_start = r_start;
    assign unit_cmd   = r_unit_cmd;
    assign unit_src   = r_unit_src;
    assign cnt1       = r_cnt1;
    assign cnt2       = r_cnt2;

endmodule

// File: tb/tb_dual_req_scheduler.sv
// Bench for dual_req_scheduler: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_dual_req_scheduler;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic [1:0] cmd1 = 2'b00;
    logic [1:0] cmd2 = 2'b00;
    logic       unit_done = 1'b0;
    logic       clr = 1'b0;
    logic       gnt1, gnt2, done1, done2, err, unit_start, unit_src;
    logic [1:0] unit_cmd;
    logic [2:0] cnt1, cnt2;

    dual_req_scheduler #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req1       (req1),
        .cmd1       (cmd1),
        .req2       (req2),
        .cmd2       (cmd2),
        .gnt1       (gnt1),
        .gnt2       (gnt2),
        .done1      (done1),
        .done2      (done2),
        .err        (err),
        .unit_start (unit_start),
        .unit_cmd   (unit_cmd),
        .unit_src   (unit_src),
        .unit_done  (unit_done),
        .clr        (clr),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age = -1 idle, 0 = grant cycle, k>=1 = k-th cycle waiting on the unit.
    int         m_age;
    bit         m_last;
    bit         m_owner;
    int         m_cnt[2];
    bit         e_gnt[2];
    bit         e_done[2];
    bit         e_err;
    bit         e_start;
    logic [1:0] e_cmd;
    bit         e_src;

    function automatic void model_reset();
        m_age = -1;
        m_last = 1'b1;
        m_owner = 1'b0;
        m_cnt = '{0, 0};
        e_gnt = '{0, 0};
        e_done = '{0, 0};
        e_err = 0;
        e_start = 0;
        e_cmd = 2'b00;
        e_src = 0;
    endfunction

    function automatic void model_step();
        e_gnt = '{0, 0};
        e_done = '{0, 0};
        e_err = 0;
        e_start = 0;
        if (m_age < 0) begin
            if (req1 || req2) begin
                m_owner = (req1 && req2) ? !m_last : req2;
                e_cmd = m_owner ? cmd2 : cmd1;
                e_src = m_owner;
                e_gnt[m_owner] = 1;
                e_start = 1;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (unit_done) begin
            e_done[m_owner] = 1;
            if (m_cnt[m_owner] < 7) m_cnt[m_owner]++;
            m_last = m_owner;
            m_age = -1;
        end else if (m_age == int'(TO)) begin
            e_err = 1;
            m_last = m_owner;
            m_age = -1;
        end else begin
            m_age++;
        end
        if (clr) m_cnt = '{0, 0};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            #1;
            chk("m_gnt1", gnt1, e_gnt[0]);
            chk("m_gnt2", gnt2, e_gnt[1]);
            chk("m_done1", done1, e_done[0]);
            chk("m_done2", done2, e_done[1]);
            chk("m_err", err, e_err);
            chk("m_start", unit_start, e_start);
            chk("m_cmd", unit_cmd, e_cmd);
            chk("m_src", unit_src, e_src);
            chk("m_cnt1", cnt1, m_cnt[0]);
            chk("m_cnt2", cnt2, m_cnt[1]);
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        unit_done = 1'b0;
        clr = 1'b0;
        nclk(2);
        reset_n = 1'b1;
    endtask

    task automatic do_cmd1(input bit with_clr);
        bit got;
        got = 0;
        req1 = 1'b1;
        cmd1 = 2'($urandom_range(0, 3));
        for (int i = 0; i < 10 && !got; i++) begin
            nclk(1);
            if (gnt1) got = 1;
        end
        chk("c1_gnt", got, 1);
        req1 = 1'b0;
        nclk(1);
        unit_done = 1'b1;
        clr = with_clr;
        nclk(1);
        unit_done = 1'b0;
        clr = 1'b0;
        chk("c1_done", done1, 1);
    endtask

    int  order[$];
    int  exp_order[4] = '{1, 2, 1, 2};
    int  cd;
    bit  prev_g;
    bit  got;
    int  pend;

    initial begin
        // Reset values
        nclk(2);
        chk("rst_gnt", {gnt1, gnt2, done1, done2, err, unit_start}, 0);
        chk("rst_cmd_src", {unit_cmd, unit_src}, 0);
        chk("rst_cnt", {cnt1, cnt2}, 0);
        reset_n = 1'b1;

        // Single command from requester 1
        req1 = 1'b1;
        cmd1 = 2'b10;
        nclk(1);
        chk("t1_gnt1", gnt1, 1);
        chk("t1_start", unit_start, 1);
        chk("t1_cmd", unit_cmd, 2'b10);
        chk("t1_src", unit_src, 0);
        req1 = 1'b0;
        nclk(3);
        unit_done = 1'b1;
        nclk(1);
        unit_done = 1'b0;
        chk("t1_done1", done1, 1);
        chk("t1_err", err, 0);
        chk("t1_cnt1", cnt1, 1);
        nclk(1);
        chk("t1_done1_off", done1, 0);

        // Both held: grants alternate starting with requester 1
        do_reset();
        req1 = 1'b1;
        req2 = 1'b1;
        cmd1 = 2'b01;
        cmd2 = 2'b10;
        cd = -1;
        prev_g = 0;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            nclk(1);
            unit_done = 1'b0;
            if (prev_g) chk("t2_gnt_width", gnt1 | gnt2, 0);
            prev_g = gnt1 | gnt2;
            if (gnt1 || gnt2) begin
                order.push_back(gnt2 ? 2 : 1);
                cd = 2;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) unit_done = 1'b1;
            end
        end
        chk("t2_ngrants", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", order[i], exp_order[i]);

        // Timeout on requester 2, then tie goes to requester 1
        do_reset();
        req2 = 1'b1;
        cmd2 = 2'b01;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            nclk(1);
            if (gnt2) got = 1;
        end
        chk("t3_gnt2", got, 1);
        req2 = 1'b0;
        nclk(4);
        chk("t3_err_early", err, 0);
        nclk(1);
        chk("t3_err", err, 1);
        chk("t3_done2", done2, 0);
        chk("t3_cnt2", cnt2, 0);
        req1 = 1'b1;
        req2 = 1'b1;
        nclk(1);
        chk("t3_gnt1", gnt1, 1);
        chk("t3_gnt2_lose", gnt2, 0);
        req1 = 1'b0;
        req2 = 1'b0;
        // Completion on the exact timeout cycle
        nclk(4);
        unit_done = 1'b1;
        nclk(1);
        unit_done = 1'b0;
        chk("t4_done1", done1, 1);
        chk("t4_err", err, 0);
        chk("t4_cnt1", cnt1, 1);
        // Stray unit_done while idle
        unit_done = 1'b1;
        nclk(1);
        unit_done = 1'b0;
        chk("t4_stray_pulses", {gnt1, gnt2, done1, done2, err, unit_start}, 0);
        chk("t4_stray_cnt1", cnt1, 1);

        // Saturation and clear priority
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_cmd1(1'b0);
            chk("t5_cnt1", cnt1, (i + 1 > 7) ? 7 : i + 1);
        end
        do_cmd1(1'b1);
        chk("t5_clr_cnt1", cnt1, 0);
        do_cmd1(1'b0);

        // Asynchronous reset during WAIT
        req1 = 1'b1;
        cmd1 = 2'b11;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            nclk(1);
            if (gnt1) got = 1;
        end
        chk("t6_gnt1", got, 1);
        req1 = 1'b0;
        nclk(1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_pulses", {gnt1, gnt2, done1, done2, err, unit_start}, 0);
        chk("t6_rst_cmd_src", {unit_cmd, unit_src}, 0);
        chk("t6_rst_cnt", {cnt1, cnt2}, 0);
        req1 = 1'b1;
        req2 = 1'b1;
        nclk(1);
        reset_n = 1'b1;
        nclk(1);
        chk("t6_tie_gnt1", gnt1, 1);
        chk("t6_tie_gnt2", gnt2, 0);
        req1 = 1'b0;
        req2 = 1'b0;

        // Randomized traffic checked by the model
        pend = 0;
        for (int i = 0; i < 3000; i++) begin
            nclk(1);
            unit_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) unit_done = 1'b1;
            end
            if (unit_start) pend = $urandom_range(1, 6);
            if ($urandom_range(0, 19) == 0) unit_done = 1'b1;
            clr = ($urandom_range(0, 24) == 0);
            if (req1) begin
                if (gnt1 || $urandom_range(0, 15) == 0) req1 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                cmd1 = 2'($urandom_range(0, 3));
            end
            if (req2) begin
                if (gnt2 || $urandom_range(0, 15) == 0) req2 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req2 = 1'b1;
                cmd2 = 2'($urandom_range(0, 3));
            end
        end
        req1 = 1'b0;
        req2 = 1'b0;
        unit_done = 1'b0;
        clr = 1'b0;
        nclk(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_req_scheduler.md
Name: dual_req_scheduler

Overview:
- Shares one multi-cycle execution unit between two requesters.
- Each requester issues a 2-bit command. The scheduler arbitrates round-robin and issues a start pulse to the unit, then waits for completion or a timeout.
- Keeps saturating 3-bit completion counters per requester for status readback.
- Sits between the two command sources and the shared unit in the same clock domain.

Parameters:
- TIMEOUT, 16, cycles in WAIT without unit_done before abort; legal 2..255.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req1  in  1  requester 1 command valid; held until gnt1
- cmd1  in  2  requester 1 command
- req2  in  1  requester 2 command valid; held until gnt2
- cmd2  in  2  requester 2 command
- gnt1  out  1  1-cycle pulse: requester 1 command accepted
- gnt2  out  1  1-cycle pulse: requester 2 command accepted
- done1  out  1  1-cycle pulse: requester 1 command completed
- done2  out  1  1-cycle pulse: requester 2 command completed
- err  out  1  1-cycle pulse: timeout abort of current command
- unit_start  out  1  1-cycle start to shared unit
- unit_cmd  out  2  latched command; stable from ISSUE until back in IDLE
- unit_src  out  1  owner of the current command: 0=req1, 1=req2
- unit_done  in  1  unit completion pulse
- clr  in  1  synchronous clear of both counters
- cnt1  out  3  saturating count of requester 1 completions
- cnt2  out  3  saturating count of requester 2 completions

Behaviour:
- Single clock domain; reset_n low asynchronously forces the reset state.
- Reset state:
  - FSM in IDLE.
  - All outputs 0: gnt1/2, done1/2, err, unit_start, unit_cmd=2'b00, unit_src=0, cnt1=cnt2=3'b000.
  - Internal last_src=1, so requester 1 wins the first tie.
  - Timer cleared.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, select that requester.
  - If both are high, select the requester opposite last_src.
  - On selection: latch cmd and src, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - unit_start=1 and gnt of the selected requester = 1 in this same cycle.
  - Timer loaded with 0; go to WAIT.
  - Latency: req sampled high in IDLE at edge n gives gnt/unit_start high in cycle n+1.
- WAIT:
  - Timer increments every cycle.
  - If unit_done=1: pulse done of the owner next cycle, set last_src=owner, increment the owner's counter, go to IDLE.
  - Else if timer==TIMEOUT-1: pulse err next cycle, set last_src=owner, no counter update, go to IDLE.
  - If unit_done arrives on the timeout cycle, it wins: completion, no err.
- unit_done in IDLE or ISSUE is ignored; it is neither counted nor flagged.
- A req drop before gnt is legal: it withdraws the request if still in IDLE. Once latched, the command is unaffected by req.
- A requester must deassert req in the cycle after gnt or it is re-arbitrated. Round-robin prevents starvation.
- Counters:
  - Saturate at 7.
  - clr=1 clears both to 0 on the next edge.
  - clr takes priority over a simultaneous increment: the result is 0.
- Reset asserted mid-command aborts without done/err pulses. The unit is responsible for its own reset.
- Minimum turnaround: done pulse, then IDLE, then next ISSUE. At most one command every 3 cycles plus unit latency.

Test Plan:
- Reset, then req1=1 cmd1=2'b10 only → next cycle gnt1=1, unit_start=1, unit_cmd=2'b10, unit_src=0. unit_done 3 cycles later → done1 pulse, cnt1=1.
- req1 and req2 both held continuously, unit_done returned 2 cycles after each start → grants alternate 1,2,1,2. First grant goes to req1 after reset; each gnt lasts exactly 1 cycle.
- TIMEOUT=4, req2 and unit_done never asserted → err pulses exactly 4 cycles after leaving ISSUE. No done2, cnt2=0, FSM back in IDLE. A following req1 is granted first.
- unit_done on the exact timeout cycle → done pulse, no err, counter incremented. Stray unit_done in IDLE → no outputs change.
- Eight completions for requester 1 → cnt1 stops at 7. clr together with a completion → cnt1=0.
- reset_n pulsed low during WAIT → all outputs 0 immediately (asynchronous). After release, the first grant goes to req1 on a tie.
